// File: rtl/clk_div_prog_pkg.sv
// Shared constants and helpers for the programmable multi-channel clock divider.
package clk_div_prog_pkg;

    localparam int unsigned DEF_DIV_RST = 50000000;
    localparam int unsigned DEF_HI_RST  = 25000000;
    localparam int unsigned DIV_MIN     = 2;

    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Settings-write and divided-clock bundle of clk_div_prog.
// The sync line exists only when CLKDIV_SYNC_EN is defined.
interface clk_div_prog_if
    import clk_div_prog_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = 31
);
    localparam int unsigned CHW = ch_width(NCH);

    logic [NCH-1:0] en;
    logic           wr_en;
    logic [CHW-1:0] wr_ch;
    logic [CW-1:0]  wr_div;
    logic [CW-1:0]  wr_hi;
    logic [NCH-1:0] clko;
    logic [NCH-1:0] tick;
`ifdef CLKDIV_SYNC_EN
    logic           sync;
`endif

    modport master (
`ifdef CLKDIV_SYNC_EN
        output sync,
`endif
        output en, wr_en, wr_ch, wr_div, wr_hi,
        input  clko, tick
    );

    modport slave (
`ifdef CLKDIV_SYNC_EN
        input  sync,
`endif
        input  en, wr_en, wr_ch, wr_div, wr_hi,
        output clko, tick
    );

endinterface

// File: rtl/clk_div_prog_chan.sv
// One divider channel: period counter, double-buffered settings, registered
// clko/tick. Settings are clamped on capture so the active pair is always legal.
module clkdiv_chan
    import clk_div_prog_pkg::*;
#(
    parameter int unsigned CW      = 31,
    parameter int unsigned DEF_DIV = DEF_DIV_RST,
    parameter int unsigned DEF_HI  = DEF_HI_RST
) (
    input  logic          clki,
    input  logic          rst_n,
    input  logic          en,
    input  logic          sync,
    input  logic          wr,
    input  logic [CW-1:0] wr_div,
    input  logic [CW-1:0] wr_hi,
    output logic          clko,
    output logic          tick
);
    localparam int unsigned   RD      = (DEF_DIV < DIV_MIN) ? DIV_MIN : DEF_DIV;
    localparam int unsigned   RH      = (DEF_HI > RD) ? RD : DEF_HI;
    localparam logic [CW-1:0] RST_DIV = CW'(RD);
    localparam logic [CW-1:0] RST_HI  = CW'(RH);
    localparam logic [CW-1:0] MIN_DIV = CW'(DIV_MIN);

    logic [CW-1:0] cnt, div_a, lo_thr, div_p, hi_p, div_c, hi_c;
    logic          pend, wrap, apply;

    always_comb begin
        div_c = (wr_div < MIN_DIV) ? MIN_DIV : wr_div;
        hi_c  = (wr_hi > div_c) ? div_c : wr_hi;
        wrap  = (cnt == div_a - CW'(1));
        // a disabled or synced channel has no period in flight, so apply at once
        apply = pend && (!en || sync || wrap);
    end

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            div_a  <= RST_DIV;
            lo_thr <= RST_DIV - RST_HI;
            div_p  <= RST_DIV;
            hi_p   <= RST_HI;
            pend   <= 1'b0;
            clko   <= 1'b0;
            tick   <= 1'b0;
        end else begin
            if (!en || sync) begin
                cnt  <= '0;
                clko <= 1'b0;
                tick <= 1'b0;
            end else begin
                cnt  <= wrap ? '0 : cnt + CW'(1);
                clko <= (cnt >= lo_thr);
                tick <= wrap;
            end
            if (apply) begin
                div_a  <= div_p;
                lo_thr <= div_p - hi_p;
            end
            // a write coinciding with an apply stays pending for the next boundary
            if (wr) begin
                div_p <= div_c;
                hi_p  <= hi_c;
                pend  <= 1'b1;
            end else if (apply) begin
                pend  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel run-time programmable clock divider: write decode plus NCH
// clkdiv_chan instances. Define CLKDIV_SYNC_EN to add a global phase-sync input.
module clk_div_prog
    import clk_div_prog_pkg::*;
#(
    parameter int unsigned NCH     = 4,
    parameter int unsigned CW      = 31,
    parameter int unsigned DEF_DIV = DEF_DIV_RST,
    parameter int unsigned DEF_HI  = DEF_HI_RST
) (
    input  logic           clki,
    input  logic           rst_n,
    clk_div_prog_if.slave  bus
);
    localparam int unsigned CHW = ch_width(NCH);

    logic           sync_w;
    logic [NCH-1:0] clko_w;
    logic [NCH-1:0] tick_w;

`ifdef CLKDIV_SYNC_EN
    assign sync_w = bus.sync;
`else
    assign sync_w = 1'b0;
`endif

    assign bus.clko = clko_w;
    assign bus.tick = tick_w;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic wr_sel;
        // out-of-range channel numbers match no instance and are dropped
        assign wr_sel = bus.wr_en && (bus.wr_ch == CHW'(i));

        clkdiv_chan #(
            .CW      (CW),
            .DEF_DIV (DEF_DIV),
            .DEF_HI  (DEF_HI)
        ) u_chan (
            .clki    (clki),
            .rst_n   (rst_n),
            .en      (bus.en[i]),
            .sync    (sync_w),
            .wr      (wr_sel),
            .wr_div  (bus.wr_div),
            .wr_hi   (bus.wr_hi),
            .clko    (clko_w[i]),
            .tick    (tick_w[i])
        );
    end

endmodule
